// File: rtl/prog_stream_loader_if.sv
// Byte-stream input and program-load output bundle for prog_stream_loader.
// The master modport is the loader itself. The slave modport is the host or
// environment that feeds bytes and observes the program-load port.
interface prog_stream_loader_if;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic        busy;
    logic        err;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, prog_en, prog_addr, prog_data, start, busy, err
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, prog_en, prog_addr, prog_data, start, busy, err
    );
endinterface

// File: rtl/prog_stream_loader.sv
// Program-stream loader.
// Receives a framed byte stream: MAGIC, a 4-byte LE word count, the LE data
// words, and an XOR checksum byte. Each data word is written to sequential
// instruction-memory addresses. The loader releases start only after a clean
// checksum. Words that were already written stay in memory when the checksum
// fails; the checksum gates start only.
module prog_stream_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_stream_loader_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // Running checksum update: XOR of every count and data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        csum_update = acc ^ b;
    endfunction

    state_t      state_r;
    state_t      state_s;

    logic [1:0]  byte_cnt_r;
    logic [31:0] word_idx_r;
    logic [31:0] len_r;
    logic [23:0] len_part_r;
    logic [23:0] word_part_r;
    logic [7:0]  csum_r;

    logic        rx_ready_r;
    logic        prog_en_r;
    logic [31:0] prog_addr_r;
    logic [31:0] prog_data_r;
    logic        start_r;
    logic        busy_r;
    logic        err_r;

    logic        rx_ready_s;
    logic        prog_en_s;
    logic [31:0] prog_addr_s;
    logic [31:0] prog_data_s;
    logic        start_s;
    logic        busy_s;
    logic        err_s;

    logic        fire_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic        len_bad_s;
    logic [31:0] len_full_s;
    logic [31:0] word_full_s;

    // Bytes arrive LSB first, so the newest byte always lands on top.
    assign fire_s      = bus.rx_valid & rx_ready_r;
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign len_full_s  = {bus.rx_data, len_part_r};
    assign word_full_s = {bus.rx_data, word_part_r};
    assign len_bad_s   = (len_full_s == 32'd0) || (len_full_s > 32'(MAX_WORDS));
    assign last_word_s = (word_idx_r == (len_r - 32'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; only an accepted byte moves the frame forward.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s && (bus.rx_data == MAGIC)) begin
                    state_s = ST_LEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (fire_s && last_byte_s) begin
                    if (len_bad_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (fire_s && last_byte_s && last_word_s) begin
                    state_s = ST_CSUM;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (fire_s) begin
                    if (bus.rx_data == csum_r) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // Output decode: next values of the registered outputs, derived from the next state.
    always_comb begin
        rx_ready_s  = 1'b0;
        busy_s      = 1'b0;
        start_s     = 1'b0;
        err_s       = 1'b0;
        prog_en_s   = 1'b0;
        prog_addr_s = prog_addr_r;
        prog_data_s = prog_data_r;
        case (state_s)
            ST_IDLE: begin
                rx_ready_s = 1'b1;
            end
            ST_LEN, ST_DATA, ST_CSUM: begin
                rx_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_RUN: begin
                start_s = 1'b1;
            end
            ST_ERR: begin
                err_s = 1'b1;
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
        // The write strobe follows the last byte of a word. It uses the
        // current state because the final word's byte also moves the FSM to CSUM.
        if ((state_r == ST_DATA) && fire_s && last_byte_s) begin
            prog_en_s   = 1'b1;
            prog_addr_s = BASE_ADDR + {word_idx_r[29:0], 2'b00};
            prog_data_s = word_full_s;
        end else begin
            prog_en_s   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_r  <= 1'b0;
            prog_en_r   <= 1'b0;
            prog_addr_r <= BASE_ADDR;
            prog_data_r <= 32'd0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            rx_ready_r  <= rx_ready_s;
            prog_en_r   <= prog_en_s;
            prog_addr_r <= prog_addr_s;
            prog_data_r <= prog_data_s;
            start_r     <= start_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
        end
    end

    // Frame datapath: byte counter, count/word packing, word index and checksum. All of them hold while no byte transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r  <= 2'd0;
            word_idx_r  <= 32'd0;
            len_r       <= 32'd0;
            len_part_r  <= 24'd0;
            word_part_r <= 24'd0;
            csum_r      <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_r  <= 2'd0;
                    word_idx_r  <= 32'd0;
                    len_r       <= 32'd0;
                    len_part_r  <= 24'd0;
                    word_part_r <= 24'd0;
                    csum_r      <= 8'd0;
                end
                ST_LEN: begin
                    if (fire_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        len_part_r <= len_full_s[31:8];
                        csum_r     <= csum_update(csum_r, bus.rx_data);
                        if (last_byte_s) begin
                            len_r <= len_full_s;
                        end
                    end
                end
                ST_DATA: begin
                    if (fire_s) begin
                        byte_cnt_r  <= byte_cnt_r + 2'd1;
                        word_part_r <= word_full_s[31:8];
                        csum_r      <= csum_update(csum_r, bus.rx_data);
                        if (last_byte_s) begin
                            word_idx_r <= word_idx_r + 32'd1;
                        end
                    end
                end
                default: begin
                    byte_cnt_r <= byte_cnt_r;
                end
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_r;
    assign bus.prog_en   = prog_en_r;
    assign bus.prog_addr = prog_addr_r;
    assign bus.prog_data = prog_data_r;
    assign bus.start     = start_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed, table-driven bench for prog_stream_loader.
module tb_prog_stream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prog_stream_loader_if bus();

    prog_stream_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(4096),
        .MAGIC(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string            name;
        int               nbytes;
        logic [19:0][7:0] bytes;
        int               gap_max;
        int               n_wr;
        logic [1:0][31:0] wa;
        logic [1:0][31:0] wd;
        logic             exp_start;
        logic             exp_err;
    } vec_t;

    vec_t vecs [6];

    logic [7:0] nom [14] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                             8'h13, 8'h00, 8'h00, 8'h00,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    // Capture every program-memory write strobe.
    always @(negedge clk) begin
        if (bus.prog_en === 1'b1) begin
            wr_addr_q.push_back(bus.prog_addr);
            wr_data_q.push_back(bus.prog_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rx_ready"},  32'(bus.rx_ready), 32'd0);
        check({tag, ".prog_en"},   32'(bus.prog_en),  32'd0);
        check({tag, ".prog_addr"}, bus.prog_addr,     32'h0000_0000);
        check({tag, ".prog_data"}, bus.prog_data,     32'h0000_0000);
        check({tag, ".start"},     32'(bus.start),    32'd0);
        check({tag, ".busy"},      32'(bus.busy),     32'd0);
        check({tag, ".err"},       32'(bus.err),      32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        check("idle.rx_ready", 32'(bus.rx_ready), 32'd1);
    endtask

    // Present one byte at a negedge; it transfers on the first posedge that
    // sees rx_ready high. The task returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int t = 0; t < 20 && !done; t++) begin
            done = (bus.rx_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b", b, bus.rx_ready);
        end
    endtask

    task automatic send_nominal();
        for (int k = 0; k < 14; k++) begin
            send_byte(nom[k]);
        end
    endtask

    task automatic check_nominal_writes(input string tag);
        logic [31:0] a;
        logic [31:0] d;
        check({tag, ".n_wr"}, 32'(wr_addr_q.size()), 32'd2);
        a = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hxxxx_xxxx;
        d = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hxxxx_xxxx;
        check({tag, ".wa0"}, a, 32'h0000_0000);
        check({tag, ".wd0"}, d, 32'h0000_0013);
        a = (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hxxxx_xxxx;
        d = (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hxxxx_xxxx;
        check({tag, ".wa1"}, a, 32'h0000_0004);
        check({tag, ".wd1"}, d, 32'hDEAD_BEEF);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // ---------------- vector table ----------------
        for (int v = 0; v < 6; v++) begin
            vecs[v].bytes     = '0;
            vecs[v].gap_max   = 0;
            vecs[v].n_wr      = 2;
            vecs[v].wa[0]     = 32'h0000_0000;
            vecs[v].wa[1]     = 32'h0000_0004;
            vecs[v].wd[0]     = 32'h0000_0013;
            vecs[v].wd[1]     = 32'hDEAD_BEEF;
            vecs[v].exp_start = 1'b1;
            vecs[v].exp_err   = 1'b0;
            vecs[v].nbytes    = 14;
            for (int k = 0; k < 14; k++) begin
                vecs[v].bytes[k] = nom[k];
            end
        end
        vecs[0].name = "nominal";
        vecs[1].name = "bad_csum";
        vecs[1].bytes[13] = 8'h34;
        vecs[1].exp_start = 1'b0;
        vecs[1].exp_err   = 1'b1;
        vecs[2].name = "garbage";
        vecs[2].nbytes = 17;
        vecs[2].bytes[0] = 8'h00;
        vecs[2].bytes[1] = 8'hFF;
        vecs[2].bytes[2] = 8'h5A;
        for (int k = 0; k < 14; k++) begin
            vecs[2].bytes[k + 3] = nom[k];
        end
        vecs[3].name = "n_zero";
        vecs[3].nbytes = 5;
        vecs[3].bytes[1] = 8'h00;
        vecs[3].n_wr = 0;
        vecs[3].exp_start = 1'b0;
        vecs[3].exp_err   = 1'b1;
        vecs[4].name = "n_max_plus1";
        vecs[4].nbytes = 5;
        vecs[4].bytes[1] = 8'h01;
        vecs[4].bytes[2] = 8'h10;
        vecs[4].n_wr = 0;
        vecs[4].exp_start = 1'b0;
        vecs[4].exp_err   = 1'b1;
        vecs[5].name = "stalls";
        vecs[5].gap_max = 5;

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int k = 0; k < vecs[v].nbytes; k++) begin
                repeat ($urandom_range(0, vecs[v].gap_max)) @(negedge clk);
                send_byte(vecs[v].bytes[k]);
            end
            check({vecs[v].name, ".start_next"}, 32'(bus.start), 32'(vecs[v].exp_start));
            check({vecs[v].name, ".err_next"},   32'(bus.err),   32'(vecs[v].exp_err));
            repeat (3) @(negedge clk);
            check({vecs[v].name, ".n_wr"}, 32'(wr_addr_q.size()), 32'(vecs[v].n_wr));
            for (int i = 0; i < vecs[v].n_wr; i++) begin
                check({vecs[v].name, ".wa"}, (wr_addr_q.size() > i) ? wr_addr_q[i] : 32'hxxxx_xxxx, vecs[v].wa[i]);
                check({vecs[v].name, ".wd"}, (wr_data_q.size() > i) ? wr_data_q[i] : 32'hxxxx_xxxx, vecs[v].wd[i]);
            end
            check({vecs[v].name, ".rx_ready_after"}, 32'(bus.rx_ready), 32'd0);
            check({vecs[v].name, ".busy_after"},     32'(bus.busy),     32'd0);
            check({vecs[v].name, ".start_held"},     32'(bus.start),    32'(vecs[v].exp_start));
            check({vecs[v].name, ".err_held"},       32'(bus.err),      32'(vecs[v].exp_err));
        end

        // ---------------- N == MAX_WORDS is accepted ----------------
        do_reset();
        send_byte(8'hA5);
        check("busy_after_magic", 32'(bus.busy), 32'd1);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        check("nmax.busy",     32'(bus.busy),     32'd1);
        check("nmax.err",      32'(bus.err),      32'd0);
        check("nmax.rx_ready", 32'(bus.rx_ready), 32'd1);

        // ---------------- reset mid-frame, then a clean frame ----------------
        do_reset();
        for (int k = 0; k < 7; k++) begin
            send_byte(nom[k]);
        end
        check("mid.busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        send_nominal();
        check("mid.start_next", 32'(bus.start), 32'd1);
        repeat (2) @(negedge clk);
        check_nominal_writes("mid");
        check("mid.err", 32'(bus.err), 32'd0);

        // ---------------- rst from RUN drops start ----------------
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("run_rst");
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
